nibble_serial_add_ctrl: RTL and testbench

Controller that sequences one shared external 4-bit adder slice to add two wide operands, one nibble per cycle, least-significant nibble first.
- Ripple carry is held in a register between nibbles.
- Operands enter through a valid/ready handshake; the result leaves through a second valid/ready handshake.
- Lets the team build 8/16/32/64-bit additions from a single 4-bit parallel adder instead of replicating slices.

---
 rtl/nibble_serial_add_ctrl.sv | 172 +++++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Drives one external 4-bit adder slice so that it adds two W-bit operands,
// one nibble per cycle, least-significant nibble first. Carry ripples between
// nibbles through carry_reg. Operands arrive on a valid/ready handshake and
// the result leaves on a second valid/ready handshake.
// Optional feature: define ADDSUB_EN to add a 'sub' input selecting a-b.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef ADDSUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_s,
  input  logic         add_co
);

  // idx needs at least one bit even when there is only one nibble
  localparam int IW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int DEPTH = 1 << IW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg;
  logic            carry_reg;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    sum_reg;
`ifdef ADDSUB_EN
  logic            sub_reg;
`endif

  logic [3:0]      a_nib [DEPTH];
  logic [3:0]      b_nib [DEPTH];
  logic            last_nib;

  // Split the operand registers into nibbles; unused slots (non power of two
  // NIBBLES) read as zero so the idx-addressed lookup is always in range.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_nib
      if (gi < NIBBLES) begin : g_real
        assign a_nib[gi] = a_reg[4*gi +: 4];
        assign b_nib[gi] = b_reg[4*gi +: 4];
      end else begin : g_pad
        assign a_nib[gi] = 4'd0;
        assign b_nib[gi] = 4'd0;
      end
    end
  endgenerate

  assign last_nib = (idx_reg == IW'(NIBBLES - 1));
  assign sum      = sum_reg;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and outputs; the slice inputs are held at zero outside RUN
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    cout       = 1'b0;
    add_a      = 4'd0;
    add_b      = 4'd0;
    add_cin    = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        add_a   = a_nib[idx_reg];
`ifdef ADDSUB_EN
        // Subtraction is a + ~b + 1; the +1 comes from the initial carry
        add_b   = b_nib[idx_reg] ^ {4{sub_reg}};
`else
        add_b   = b_nib[idx_reg];
`endif
        add_cin = carry_reg;
        if (last_nib) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        cout      = carry_reg;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: capture operands on accept, then fold one slice result per RUN cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
`ifdef ADDSUB_EN
      sub_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            idx_reg   <= '0;
            sum_reg   <= '0;
`ifdef ADDSUB_EN
            sub_reg   <= sub;
            carry_reg <= sub ? 1'b1 : cin;
`else
            carry_reg <= cin;
`endif
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx_reg == IW'(i)) begin
              sum_reg[4*i +: 4] <= add_s;
            end
          end
          carry_reg <= add_co;
          if (!last_nib) begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed testbench for nibble_serial_add_ctrl (NIBBLES=4).
// Models the external 4-bit adder slice; checks handshakes, latency,
// slice drive sequences, backpressure and mid-operation reset.
// Define ADDSUB_EN to also exercise subtraction.
module tb_nibble_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        busy;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_s;
  logic        add_co;

  int errors = 0;
  int checks = 0;

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADDSUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_co    (add_co)
  );

  // External 4-bit adder slice
  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accept edge, then scramble the inputs
  task automatic accept_op(input logic [15:0] a_v, input logic [15:0] b_v,
                           input logic cin_v, input logic sub_v);
    check("acc_in_ready", in_ready, 1);
    a        = a_v;
    b        = b_v;
    cin      = cin_v;
    sub      = sub_v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a        = ~a_v;
    b        = ~b_v;
    cin      = ~cin_v;
    sub      = ~sub_v;
  endtask

  // Watch the four RUN cycles and record what reaches the slice
  task automatic collect(output logic [15:0] aseq, output logic [3:0] cseq);
    aseq = '0;
    cseq = '0;
    for (int k = 0; k < 4; k++) begin
      check("run_out_valid", out_valid, 0);
      check("run_busy", busy, 1);
      check("run_in_ready", in_ready, 0);
      aseq[4*k +: 4] = add_a;
      cseq[k]        = add_cin;
      step();
    end
  endtask

  task automatic finish_op(input string tag, input logic [15:0] exp_sum, input logic exp_cout);
    check("done_out_valid", out_valid, 1);
    check("done_in_ready", in_ready, 0);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, cout, exp_cout);
    check("done_add_a_idle", add_a, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hs_out_valid", out_valid, 0);
    check("hs_in_ready", in_ready, 1);
    check("hs_busy", busy, 0);
    $display("op %s: sum=0x%04h cout=%0d", tag, exp_sum, exp_cout);
  endtask

  task automatic full_op(input string tag, input logic [15:0] a_v, input logic [15:0] b_v,
                         input logic cin_v, input logic sub_v,
                         input logic [15:0] exp_sum, input logic exp_cout);
    logic [15:0] aseq;
    logic [3:0]  cseq;
    accept_op(a_v, b_v, cin_v, sub_v);
    collect(aseq, cseq);
    finish_op(tag, exp_sum, exp_cout);
  endtask

  initial begin
    logic [15:0] aseq;
    logic [3:0]  cseq;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;

    // Reset state
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_busy", busy, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_cin", add_cin, 0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);
    step();

    // 0x1234 + 0x4321: slice sees nibbles 4,3,2,1 with no carry
    accept_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    collect(aseq, cseq);
    check("t1_add_a_seq", aseq, 16'h1234);
    check("t1_add_cin_seq", cseq, 4'b0000);
    finish_op("t1", 16'h5555, 1'b0);

    // 0xFFFF + 1: carry ripples through every nibble
    accept_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    collect(aseq, cseq);
    check("t2_add_a_seq", aseq, 16'hFFFF);
    check("t2_add_cin_seq", cseq, 4'b1110);
    finish_op("t2", 16'h0000, 1'b1);

    // Carry-in only, then all zero
    full_op("t3", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    full_op("t4", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Backpressure: hold the result, ignore a new request meanwhile
    accept_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    collect(aseq, cseq);
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_sum", sum, 16'h3333);
      check("bp_cout", cout, 0);
      if (k == 2) begin
        a        = 16'hAAAA;
        b        = 16'h5555;
        cin      = 1'b1;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    finish_op("bp", 16'h3333, 1'b0);
    full_op("bp_next", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0);

    // Reset during the second RUN cycle aborts the operation
    accept_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    check("mr_busy", busy, 1);
    step();
    check("mr_busy2", busy, 1);
    rst_n = 1'b0;
    step();
    check("mr_in_ready_low", in_ready, 0);
    check("mr_out_valid", out_valid, 0);
    check("mr_sum", sum, 0);
    check("mr_add_a", add_a, 0);
    rst_n = 1'b1;
    #1;
    check("mr_in_ready_rel", in_ready, 1);
    step();
    for (int k = 0; k < 5; k++) begin
      check("mr_no_out_valid", out_valid, 0);
      step();
    end
    full_op("mr_next", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0);

`ifdef ADDSUB_EN
    // Subtraction: cout=1 means no borrow
    full_op("sub1", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    full_op("sub2", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    full_op("sub0", 16'h0007, 16'h0005, 1'b0, 1'b0, 16'h000C, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
